time_field_counter: RTL and testbench

Parametrised counter for one calendar/clock field (second, minute, hour, day, month) in the millennium clock. It generalises the fixed 0–23 hour counter with configurable width and range, a runtime upper bound for month-length-dependent fields, and synchronous, edge-detected manual adjustment. Instances chain through `carry_in`/`carry_out` from seconds up to years. All state sits in one clock domain, which removes the dual-process drive of the old hour counter.

---
 rtl/time_field_counter.sv | 183 ++++++++++++++++++
 tb/tb_time_field_counter.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/time_field_counter.sv
// -----------------------------------------------------------------------------
// time_field_counter
//
// One field (second, minute, hour, day, month) of the millennium clock.
// The field counts from MIN_VAL up to an effective maximum. At that maximum
// it wraps and emits a one-cycle carry to the next field. The user can step
// the field up or down with edge-detected buttons while it is selected. A
// runtime bound (max_dyn) lets day fields follow the length of the month.
//
// Optional feature macro: HOLD_REPEAT_EN
//   When defined, holding a button after its stepping edge auto-repeats.
//   The first repeat step comes REPEAT_DELAY cycles after the initial step,
//   and later steps come every REPEAT_PERIOD cycles. When the macro is
//   undefined, only rising edges step.
//
// Ports:
//   clk_1Hz        in  1      single clock, rising edge
//   rst            in  1      synchronous, active-high reset
//   en_1           in  1      global count enable
//   carry_in       in  1      increment request from the lower field
//   up / down      in  1      debounced adjust buttons (level)
//   select_item    in  3      adjust-field selector
//   max_dyn        in  WIDTH  runtime upper bound (all-ones when unused)
//   value          out WIDTH  current field value, registered
//   carry_out      out 1      one-cycle wrap pulse, registered
//   adjust_active  out 1      select match from the previous cycle
// -----------------------------------------------------------------------------
module time_field_counter #(
   parameter int unsigned WIDTH         = 6,
   parameter int unsigned MIN_VAL       = 0,
   parameter int unsigned MAX_VAL       = 59,
   parameter logic [2:0]  SELECT_CODE   = 3'b010,
   parameter int unsigned REPEAT_DELAY  = 4,
   parameter int unsigned REPEAT_PERIOD = 2
) (
   input  logic             clk_1Hz,
   input  logic             rst,
   input  logic             en_1,
   input  logic             carry_in,
   input  logic             up,
   input  logic             down,
   input  logic [2:0]       select_item,
   input  logic [WIDTH-1:0] max_dyn,
   output logic [WIDTH-1:0] value,
   output logic             carry_out,
   output logic             adjust_active
);

   localparam logic [WIDTH-1:0] MIN_W = WIDTH'(MIN_VAL);
   localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX_VAL);

   if ((MIN_VAL > MAX_VAL) || (64'(MAX_VAL) >= (64'd1 << WIDTH)) ||
       (REPEAT_DELAY == 0) || (REPEAT_PERIOD == 0)) begin : g_param_check
      $error("time_field_counter: illegal parameter combination");
   end

   logic             sel;
   logic             below_min;
   logic [WIDTH-1:0] eff_max;
   logic             at_max;
   logic [WIDTH-1:0] inc_val;
   logic [WIDTH-1:0] dec_val;
   logic             up_prev, down_prev;
   logic             up_lock, down_lock;
   logic             up_rise, down_rise;
   logic             edge_up, edge_down;
   logic             step_up, step_down;
   logic             rpt_fire;
   logic             rpt_dir_up;

   // With MIN_VAL == 0 no bound can fall below the minimum. Splitting the
   // branch keeps an always-false unsigned compare out of the netlist.
   if (MIN_VAL == 0) begin : g_min_zero
      assign below_min = 1'b0;
   end else begin : g_min_nonzero
      assign below_min = (max_dyn < MIN_W);
   end

   // NOTE: every signal driven in always_comb gets a value on every path;
   //       a missed branch would infer a latch.
   always_comb begin
      eff_max = MAX_W;
      if (below_min)
         eff_max = MIN_W;
      else if (max_dyn < MAX_W)
         eff_max = max_dyn;

      sel     = (select_item == SELECT_CODE);
      at_max  = (value == eff_max);
      inc_val = at_max ? MIN_W : value + WIDTH'(1);
      dec_val = (value == MIN_W) ? eff_max : value - WIDTH'(1);

      // A lock blocks a button that was already held through reset.
      up_rise   = up   & ~up_prev   & ~up_lock;
      down_rise = down & ~down_prev & ~down_lock;

      // Simultaneous rising edges cancel each other.
      edge_up   = sel & up_rise   & ~down_rise;
      edge_down = sel & down_rise & ~up_rise;

      step_up   = edge_up   | (rpt_fire &  rpt_dir_up);
      step_down = edge_down | (rpt_fire & ~rpt_dir_up);
   end

`ifdef HOLD_REPEAT_EN
   localparam int unsigned RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ?
                                     REPEAT_DELAY : REPEAT_PERIOD;
   localparam int unsigned RPT_W   = $clog2(RPT_MAX + 1);
   localparam logic [RPT_W-1:0] RPT_DELAY_C  = RPT_W'(REPEAT_DELAY);
   localparam logic [RPT_W-1:0] RPT_PERIOD_C = RPT_W'(REPEAT_PERIOD);

   logic             rpt_active;
   logic             rpt_first;  // still waiting for the first (long) delay
   logic             rpt_hold;
   logic [RPT_W-1:0] rpt_cnt;    // cycles since the last step of this hold

   always_comb begin
      rpt_hold = rpt_active & sel & ~(up & down) & (rpt_dir_up ? up : down);
      rpt_fire = rpt_hold & (rpt_cnt == (rpt_first ? RPT_DELAY_C : RPT_PERIOD_C));
   end

   always_ff @(posedge clk_1Hz) begin
      if (rst) begin
         rpt_active <= 1'b0;
         rpt_dir_up <= 1'b0;
         rpt_first  <= 1'b0;
         rpt_cnt    <= '0;
      end else if (edge_up || edge_down) begin
         rpt_active <= 1'b1;
         rpt_dir_up <= edge_up;
         rpt_first  <= 1'b1;
         rpt_cnt    <= RPT_W'(1);
      end else if (rpt_fire) begin
         rpt_first  <= 1'b0;
         rpt_cnt    <= RPT_W'(1);
      end else if (rpt_hold) begin
         rpt_cnt    <= rpt_cnt + RPT_W'(1);
      end else begin
         rpt_active <= 1'b0;
         rpt_first  <= 1'b0;
         rpt_cnt    <= '0;
      end
   end
`else
   assign rpt_fire   = 1'b0;
   assign rpt_dir_up = 1'b0;
`endif

   // NOTE: sequential state uses non-blocking assignments only, so every
   //       register samples the pre-edge values of its neighbours.
   always_ff @(posedge clk_1Hz) begin
      if (rst) begin
         value         <= MIN_W;
         carry_out     <= 1'b0;
         adjust_active <= 1'b0;
         up_prev       <= 1'b0;
         down_prev     <= 1'b0;
         // A button held across reset stays locked until it is released.
         up_lock       <= up;
         down_lock     <= down;
      end else begin
         up_prev       <= up;
         down_prev     <= down;
         up_lock       <= up_lock & up;
         down_lock     <= down_lock & down;
         adjust_active <= sel;
         carry_out     <= 1'b0;

         if (value > eff_max) begin
            value <= eff_max;
         end else if (sel) begin
            if (step_up)
               value <= inc_val;
            else if (step_down)
               value <= dec_val;
         end else if (en_1 && carry_in) begin
            value     <= inc_val;
            carry_out <= at_max;
         end
      end
   end

endmodule

// File: tb/tb_time_field_counter.sv
// -----------------------------------------------------------------------------
// tb_time_field_counter
//
// Self-checking bench. It runs two instances: an hour field (0..23,
// select 3'b010) and a day field (1..31, select 3'b011).
//   - A vector table covers reset, counting, wrap, adjust and edge detect.
//   - Hand-written sequences cover the dynamic bound, clamp and hold-repeat.
//   - A randomized phase checks both instances every cycle against a
//     behavioural model built from the field's rules.
// -----------------------------------------------------------------------------
module tb_time_field_counter;

   localparam logic [2:0] HOUR_CODE = 3'b010;
   localparam logic [2:0] DAY_CODE  = 3'b011;
   localparam int         DELAY     = 4;
   localparam int         PERIOD    = 2;

   logic       clk_1Hz;
   logic       rst, en_1, carry_in, up, down;
   logic [2:0] select_item;
   logic [4:0] hour_max, day_max;
   logic [4:0] hour_val, day_val;
   logic       hour_co, day_co, hour_act, day_act;

   time_field_counter #(
      .WIDTH(5), .MIN_VAL(0), .MAX_VAL(23), .SELECT_CODE(HOUR_CODE),
      .REPEAT_DELAY(DELAY), .REPEAT_PERIOD(PERIOD)
   ) u_hour (
      .clk_1Hz(clk_1Hz), .rst(rst), .en_1(en_1), .carry_in(carry_in),
      .up(up), .down(down), .select_item(select_item), .max_dyn(hour_max),
      .value(hour_val), .carry_out(hour_co), .adjust_active(hour_act)
   );

   time_field_counter #(
      .WIDTH(5), .MIN_VAL(1), .MAX_VAL(31), .SELECT_CODE(DAY_CODE),
      .REPEAT_DELAY(DELAY), .REPEAT_PERIOD(PERIOD)
   ) u_day (
      .clk_1Hz(clk_1Hz), .rst(rst), .en_1(en_1), .carry_in(carry_in),
      .up(up), .down(down), .select_item(select_item), .max_dyn(day_max),
      .value(day_val), .carry_out(day_co), .adjust_active(day_act)
   );

   initial clk_1Hz = 1'b0;
   always #5 clk_1Hz = ~clk_1Hz;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input int actual, input int expected);
      n_checks++;
      if (actual == expected)
         n_pass++;
      else
         $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
   endtask

   // ---------------- behavioural reference model ----------------
   typedef struct {
      int v;
      bit co;
      bit act;
      bit up_p, dn_p;      // last sampled button levels
      bit up_hold_rst;     // button held through reset, needs a release
      bit dn_hold_rst;
      bit rep_on, rep_up;  // a hold that began with a stepping edge
      int held;            // edges since that stepping edge
   } mstate_t;

   function automatic int wrap_add(int v, int lo, int emax, int delta);
      int span = emax - lo + 1;
      return lo + ((v - lo + delta + span) % span);
   endfunction

   function automatic mstate_t model_step(mstate_t s, int lo, int hi, int dyn,
                                          logic [2:0] code, bit r, bit en,
                                          bit cin, bit u, bit d,
                                          logic [2:0] si);
      mstate_t n = s;
      int  emax;
      bit  sel, ur, dr, fire, step_u, step_d;
      if (r) begin
         n.v = lo;  n.co = 0;  n.act = 0;
         n.up_p = 0;  n.dn_p = 0;
         n.up_hold_rst = u;  n.dn_hold_rst = d;
         n.rep_on = 0;  n.rep_up = 0;  n.held = 0;
         return n;
      end
      emax = (dyn < lo) ? lo : ((dyn < hi) ? dyn : hi);
      sel  = (si == code);
      ur   = u && !s.up_p && !s.up_hold_rst;
      dr   = d && !s.dn_p && !s.dn_hold_rst;
      n.up_p = u;  n.dn_p = d;
      n.up_hold_rst = s.up_hold_rst && u;
      n.dn_hold_rst = s.dn_hold_rst && d;
      n.act = sel;
      n.co  = 0;
      fire  = 0;
`ifdef HOLD_REPEAT_EN
      begin
         bit hold_ok;
         hold_ok = s.rep_on && sel && !(u && d) && (s.rep_up ? u : d);
         fire = hold_ok && (s.held == DELAY ||
                            (s.held > DELAY && (s.held - DELAY) % PERIOD == 0));
         if (sel && (ur != dr)) begin
            n.rep_on = 1;  n.rep_up = ur;  n.held = 1;
         end else if (hold_ok) begin
            n.held = s.held + 1;
         end else begin
            n.rep_on = 0;  n.held = 0;
         end
      end
`endif
      step_u = sel && ((ur && !dr) || (fire &&  s.rep_up));
      step_d = sel && ((dr && !ur) || (fire && !s.rep_up));
      if (s.v > emax)
         n.v = emax;
      else if (sel) begin
         if (step_u)      n.v = wrap_add(s.v, lo, emax, 1);
         else if (step_d) n.v = wrap_add(s.v, lo, emax, -1);
      end else if (en && cin) begin
         n.v  = wrap_add(s.v, lo, emax, 1);
         n.co = (s.v == emax);
      end
      return n;
   endfunction

   mstate_t hm, dm;

   // Advance the models with the current inputs, clock once, then settle.
   task automatic tick();
      hm = model_step(hm, 0, 23, int'(hour_max), HOUR_CODE, rst, en_1,
                      carry_in, up, down, select_item);
      dm = model_step(dm, 1, 31, int'(day_max), DAY_CODE, rst, en_1,
                      carry_in, up, down, select_item);
      @(posedge clk_1Hz);
      #1;
   endtask

   // ---------------- vector table (hour instance) ----------------
   typedef struct {
      bit         r, e, c, u, d;
      logic [2:0] si;
      int         exp_v;
      bit         exp_co;
      bit         exp_act;
   } vec_t;

   function automatic vec_t mk(bit r, bit e, bit c, bit u, bit d,
                               logic [2:0] si, int v, bit co);
      vec_t x;
      x.r = r;  x.e = e;  x.c = c;  x.u = u;  x.d = d;  x.si = si;
      x.exp_v = v;  x.exp_co = co;
      x.exp_act = !r && (si == HOUR_CODE);
      return x;
   endfunction

   vec_t vecs[$];
   int   hold_exp[10];
   logic [4:0] day_pool[7];
   logic [4:0] hour_pool[4];
   logic [2:0] sel_pool[4];

   initial begin
      rst = 0;  en_1 = 0;  carry_in = 0;  up = 0;  down = 0;
      select_item = 3'b000;  hour_max = 5'h1F;  day_max = 5'h1F;

      // reset, then 24 counts: 1..23, then wrap to 0 with a single carry
      vecs.push_back(mk(1, 0, 0, 0, 0, 3'b000, 0, 0));
      for (int k = 1; k <= 24; k++)
         vecs.push_back(mk(0, 1, 1, 0, 0, 3'b000, k % 24, k == 24));
      vecs.push_back(mk(0, 0, 0, 0, 0, 3'b000, 0, 0));
      // adjust: down wraps to max, up wraps to min, simultaneous edges cancel
      vecs.push_back(mk(0, 0, 0, 0, 0, HOUR_CODE, 0, 0));
      vecs.push_back(mk(0, 0, 0, 0, 1, HOUR_CODE, 23, 0));
      vecs.push_back(mk(0, 0, 0, 0, 0, HOUR_CODE, 23, 0));
      vecs.push_back(mk(0, 0, 0, 1, 0, HOUR_CODE, 0, 0));
      vecs.push_back(mk(0, 0, 0, 0, 0, HOUR_CODE, 0, 0));
      vecs.push_back(mk(0, 0, 0, 1, 1, HOUR_CODE, 0, 0));
      vecs.push_back(mk(0, 0, 0, 0, 0, HOUR_CODE, 0, 0));
      // carry during adjust is dropped, not queued
      vecs.push_back(mk(0, 1, 1, 0, 0, HOUR_CODE, 0, 0));
      vecs.push_back(mk(0, 1, 0, 0, 0, 3'b000, 0, 0));
      // press before selection does not step; re-press steps once
      vecs.push_back(mk(0, 0, 0, 1, 0, 3'b000, 0, 0));
      vecs.push_back(mk(0, 0, 0, 1, 0, HOUR_CODE, 0, 0));
      vecs.push_back(mk(0, 0, 0, 1, 0, HOUR_CODE, 0, 0));
      vecs.push_back(mk(0, 0, 0, 0, 0, HOUR_CODE, 0, 0));
      vecs.push_back(mk(0, 0, 0, 1, 0, HOUR_CODE, 1, 0));
      vecs.push_back(mk(0, 0, 0, 0, 0, HOUR_CODE, 1, 0));
      // count to 7, hold up, reset mid-hold, needs release and re-press
      for (int k = 2; k <= 7; k++)
         vecs.push_back(mk(0, 1, 1, 0, 0, 3'b000, k, 0));
      vecs.push_back(mk(0, 0, 0, 1, 0, 3'b000, 7, 0));
      vecs.push_back(mk(0, 0, 0, 1, 0, HOUR_CODE, 7, 0));
      vecs.push_back(mk(1, 0, 0, 1, 0, HOUR_CODE, 0, 0));
      vecs.push_back(mk(0, 0, 0, 1, 0, HOUR_CODE, 0, 0));
      vecs.push_back(mk(0, 0, 0, 1, 0, HOUR_CODE, 0, 0));
      vecs.push_back(mk(0, 0, 0, 0, 0, HOUR_CODE, 0, 0));
      vecs.push_back(mk(0, 0, 0, 1, 0, HOUR_CODE, 1, 0));
      vecs.push_back(mk(0, 0, 0, 0, 0, HOUR_CODE, 1, 0));

      for (int i = 0; i < vecs.size(); i++) begin
         rst = vecs[i].r;  en_1 = vecs[i].e;  carry_in = vecs[i].c;
         up = vecs[i].u;   down = vecs[i].d;  select_item = vecs[i].si;
         tick();
         check($sformatf("vec%0d_value", i), int'(hour_val), vecs[i].exp_v);
         check($sformatf("vec%0d_carry", i), int'(hour_co), int'(vecs[i].exp_co));
         check($sformatf("vec%0d_active", i), int'(hour_act), int'(vecs[i].exp_act));
      end

      // ---------------- day field: dynamic bound and clamp ----------------
      rst = 1;  en_1 = 0;  carry_in = 0;  up = 0;  down = 0;
      select_item = 3'b000;  day_max = 5'd28;
      tick();
      check("day_reset_value", int'(day_val), 1);
      check("day_reset_carry", int'(day_co), 0);
      rst = 0;  en_1 = 1;  carry_in = 1;
      repeat (27) tick();
      check("day_at_28", int'(day_val), 28);
      tick();
      check("day_wrap28_value", int'(day_val), 1);
      check("day_wrap28_carry", int'(day_co), 1);
      en_1 = 0;
      tick();
      check("day_carry_one_cycle", int'(day_co), 0);
      day_max = 5'd31;  en_1 = 1;
      repeat (29) tick();
      check("day_at_30", int'(day_val), 30);
      en_1 = 0;  day_max = 5'd28;
      tick();
      check("day_clamp_value", int'(day_val), 28);
      check("day_clamp_carry", int'(day_co), 0);
      day_max = 5'd0;
      tick();
      check("day_below_min_clamp", int'(day_val), 1);
      en_1 = 1;
      tick();
      check("day_single_value_wrap", int'(day_val), 1);
      check("day_single_value_carry", int'(day_co), 1);
      en_1 = 0;  carry_in = 0;  day_max = 5'd31;

      // ---------------- hour field: hold up from 5 for 10 cycles ----------
`ifdef HOLD_REPEAT_EN
      hold_exp = '{6, 6, 6, 6, 7, 7, 8, 8, 9, 9};
`else
      hold_exp = '{6, 6, 6, 6, 6, 6, 6, 6, 6, 6};
`endif
      rst = 1;
      tick();
      rst = 0;  en_1 = 1;  carry_in = 1;
      repeat (5) tick();
      check("hold_start_value", int'(hour_val), 5);
      en_1 = 0;  carry_in = 0;  select_item = HOUR_CODE;
      tick();
      up = 1;
      for (int i = 0; i < 10; i++) begin
         tick();
         check($sformatf("hold_cycle%0d", i), int'(hour_val), hold_exp[i]);
      end
      up = 0;
      tick();
      check("hold_release", int'(hour_val), hold_exp[9]);

      // ---------------- randomized phase vs reference model --------------
      day_pool  = '{5'd0, 5'd1, 5'd15, 5'd28, 5'd29, 5'd30, 5'd31};
      hour_pool = '{5'd31, 5'd23, 5'd20, 5'd10};
      sel_pool  = '{3'b000, HOUR_CODE, DAY_CODE, 3'b101};
      rst = 1;
      tick();
      rst = 0;
      for (int c = 0; c < 600; c++) begin
         rst      = ($urandom_range(63) == 0);
         en_1     = ($urandom_range(7) != 0);
         carry_in = 1'($urandom_range(1));
         if ($urandom_range(5) == 0) up   = ~up;
         if ($urandom_range(5) == 0) down = ~down;
         if ($urandom_range(7) == 0)  select_item = sel_pool[$urandom_range(3)];
         if ($urandom_range(15) == 0) day_max     = day_pool[$urandom_range(6)];
         if ($urandom_range(15) == 0) hour_max    = hour_pool[$urandom_range(3)];
         tick();
         check($sformatf("rand%0d_hour_value", c), int'(hour_val), hm.v);
         check($sformatf("rand%0d_hour_carry", c), int'(hour_co), int'(hm.co));
         check($sformatf("rand%0d_hour_active", c), int'(hour_act), int'(hm.act));
         check($sformatf("rand%0d_day_value", c), int'(day_val), dm.v);
         check($sformatf("rand%0d_day_carry", c), int'(day_co), int'(dm.co));
         check($sformatf("rand%0d_day_active", c), int'(day_act), int'(dm.act));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
